// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: single-word command port to bus,
// pipelined in-order reads returned through a response FIFO.
module avalon_mm_master #(
    parameter int ADDRESSWIDTH = 8,
    parameter int MAX_PENDING  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_address,
    input  logic [31:0]             cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [ADDRESSWIDTH-1:0] avm_address,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    input  logic [31:0]             avm_readdata,
    output logic                    busy,
    output logic                    protocol_error
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam logic [CW-1:0] CMAX  = CW'(MAX_PENDING);
    localparam logic [PW-1:0] PLAST = PW'(MAX_PENDING - 1);

    logic                    pending_q, pending_d;
    logic                    is_write_q, is_write_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [CW-1:0]           owed_q, owed_d;
    logic [CW-1:0]           brd_q, brd_d;
    logic                    perr_q, perr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           wp_q, wp_d;
    logic [PW-1:0]           rp_q, rp_d;
    logic [31:0]             mem_q [MAX_PENDING];

    logic slot_free, accept, bus_done, rd_done;
    logic rsp_pop, rdv_ok, rdv_bad;

    assign slot_free = !pending_q || !avm_waitrequest;
    assign cmd_ready = !reset && slot_free && (owed_q < CMAX);
    assign accept    = cmd_valid && cmd_ready;
    assign bus_done  = pending_q && !avm_waitrequest;
    assign rd_done   = bus_done && !is_write_q;
    assign rsp_valid = cnt_q != '0;
    assign rsp_pop   = rsp_valid && rsp_ready;
    // Data counts only if a bus read is outstanding or completing now.
    assign rdv_ok    = avm_readdatavalid && ((brd_q != '0) || rd_done);
    assign rdv_bad   = avm_readdatavalid && !rdv_ok;

    assign avm_read      = pending_q && !is_write_q;
    assign avm_write     = pending_q && is_write_q;
    assign avm_address   = addr_q;
    assign avm_writedata = data_q;
    assign rsp_data      = mem_q[rp_q];
    assign busy          = pending_q || (owed_q != '0);
    assign protocol_error = perr_q;

    // Next-state for request register, credit/bus counters and FIFO.
    always_comb begin
        pending_d  = pending_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        owed_d     = owed_q;
        brd_d      = brd_q;
        perr_d     = perr_q | rdv_bad;
        cnt_d      = cnt_q;
        wp_d       = wp_q;
        rp_d       = rp_q;

        if (accept) begin
            pending_d  = 1'b1;
            is_write_d = cmd_write;
            addr_d     = cmd_address;
            data_d     = cmd_data;
        end else if (bus_done) begin
            pending_d = 1'b0;
        end

        case ({accept && !cmd_write, rsp_pop})
            2'b10:   owed_d = owed_q + CW'(1);
            2'b01:   owed_d = owed_q - CW'(1);
            default: owed_d = owed_q;
        endcase

        case ({rd_done, rdv_ok})
            2'b10:   brd_d = brd_q + CW'(1);
            2'b01:   brd_d = brd_q - CW'(1);
            default: brd_d = brd_q;
        endcase

        case ({rdv_ok, rsp_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (rdv_ok) begin
            wp_d = (wp_q == PLAST) ? '0 : wp_q + PW'(1);
        end
        if (rsp_pop) begin
            rp_d = (rp_q == PLAST) ? '0 : rp_q + PW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            owed_q     <= '0;
            brd_q      <= '0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
        end else begin
            pending_q  <= pending_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            owed_q     <= owed_d;
            brd_q      <= brd_d;
            perr_q     <= perr_d;
            cnt_q      <= cnt_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
        end
    end

    // Response storage; contents are meaningless unless counted valid.
    always_ff @(posedge clk) begin
        if (!reset && rdv_ok) begin
            mem_q[wp_q] <= avm_readdata;
        end
    end

endmodule
